ioctl_upload_reader: RTL and testbench

//  Read-side counterpart of the ROM download writer. Serves host upload requests (ioctl_rd + addr) by fetching
//  16-bit words from an SDRAM port with toggle req/ack, then returns the addressed byte on ioctl_din.

---
 rtl/ioctl_upload_reader_if.sv | 28 ++
 rtl/ioctl_upload_reader.sv | 211 +++++++++++++++++++++
 tb/tb_ioctl_upload_reader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_upload_reader_if.sv
// Upload-side (data_io) and SDRAM-port signals of ioctl_upload_reader.
// slave = the reader itself, master = host / SDRAM side.
interface ioctl_upload_reader_if #(
   parameter int AW = 23
);
   logic          ioctl_upload;
   logic          ioctl_rd;
   logic [AW:0]   ioctl_addr;
   logic [7:0]    ioctl_din;
   logic          din_valid;
   logic          port_req;
   logic          port_ack;
   logic [AW-1:0] port_a;
   logic [15:0]   port_q;
   logic          busy;
   logic          err_timeout;
   logic          err_overrun;

   modport slave (
      input  ioctl_upload, ioctl_rd, ioctl_addr, port_ack, port_q,
      output ioctl_din, din_valid, port_req, port_a, busy, err_timeout, err_overrun
   );

   modport master (
      output ioctl_upload, ioctl_rd, ioctl_addr, port_ack, port_q,
      input  ioctl_din, din_valid, port_req, port_a, busy, err_timeout, err_overrun
   );
endinterface

// File: rtl/ioctl_upload_reader.sv
// Upload read-back: serves data_io byte reads from a one-word cache filled over a toggle req/ack SDRAM port.
// Define IOCTL_UPLOAD_PREFETCH_EN to add a next-word prefetch buffer (PREF state).
module ioctl_upload_reader #(
   parameter int AW      = 23,
   parameter int TIMEOUT = 1023
) (
   input logic                  clk_sys,
   input logic                  reset,
   ioctl_upload_reader_if.slave bus
);
   localparam int TW = ($clog2(TIMEOUT + 1) < 10) ? 10 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

`ifdef IOCTL_UPLOAD_PREFETCH_EN
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PREF} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_WAIT} state_t;
`endif

   state_t        state_q, state_d;
   logic          upl_q;
   logic [7:0]    din_q, din_d;
   logic          dv_q, dv_d;
   logic          req_q, req_d;
   logic [AW-1:0] a_q, a_d;
   logic          eto_q, eto_d, eov_q, eov_d;
   logic [15:0]   cdat_q, cdat_d;
   logic [AW-1:0] ctag_q, ctag_d;
   logic          cv_q, cv_d;
   logic          pv_q, pv_d;
   logic [AW:0]   paddr_q, paddr_d;
   logic [AW:0]   cur_q, cur_d;
   logic          iss_q, iss_d;
   logic          sil_q, sil_d;
   logic [TW-1:0] tmr_q, tmr_d;
`ifdef IOCTL_UPLOAD_PREFETCH_EN
   logic [15:0]   fdat_q, fdat_d;
   logic [AW-1:0] ftag_q, ftag_d;
   logic          fv_q, fv_d;
   logic          hit_f;
`endif

   logic          upl_fall, upl_rise, rd_ok, aligned, quiet, srv_v, hit_c;
   logic [AW:0]   srv_a;
   logic [AW-1:0] srv_w;

   assign upl_fall = upl_q & ~bus.ioctl_upload;
   assign upl_rise = ~upl_q & bus.ioctl_upload;
   assign rd_ok    = bus.ioctl_rd & bus.ioctl_upload;
   assign aligned  = (req_q == bus.port_ack);
   // a fetch still in flight when the session ends completes without touching outputs or cache
   assign quiet    = sil_q | upl_fall;
   assign srv_v    = (pv_q & ~upl_fall) | rd_ok;
   assign srv_a    = pv_q ? paddr_q : bus.ioctl_addr;
   assign srv_w    = srv_a[AW:1];
   assign hit_c    = cv_q && (ctag_q == srv_w);
`ifdef IOCTL_UPLOAD_PREFETCH_EN
   assign hit_f    = fv_q && (ftag_q == srv_w);
`endif

   always_comb begin
      state_d = state_q;  din_d = din_q;    dv_d   = 1'b0;   req_d = req_q;
      a_d     = a_q;      eto_d = eto_q;    eov_d  = eov_q;
      cdat_d  = cdat_q;   ctag_d = ctag_q;  cv_d   = cv_q;
      pv_d    = pv_q;     paddr_d = paddr_q; cur_d = cur_q;
      iss_d   = iss_q;    sil_d = sil_q;    tmr_d  = tmr_q;
`ifdef IOCTL_UPLOAD_PREFETCH_EN
      fdat_d  = fdat_q;   ftag_d = ftag_q;  fv_d   = fv_q;
`endif
      if (upl_rise) begin
         eto_d = 1'b0;
         eov_d = 1'b0;
      end
      if (state_q != S_IDLE && rd_ok) begin
         if (pv_q) eov_d = 1'b1;
         else begin
            pv_d    = 1'b1;
            paddr_d = bus.ioctl_addr;
         end
      end

      case (state_q)
         S_IDLE: begin
            // pending request has priority; a same-cycle strobe takes its slot
            pv_d = pv_q & rd_ok;
            if (pv_q && rd_ok) paddr_d = bus.ioctl_addr;
            if (srv_v) begin
               if (hit_c) begin
                  din_d = srv_a[0] ? cdat_q[15:8] : cdat_q[7:0];
                  dv_d  = 1'b1;
               end
`ifdef IOCTL_UPLOAD_PREFETCH_EN
               else if (hit_f) begin
                  din_d  = srv_a[0] ? fdat_q[15:8] : fdat_q[7:0];
                  dv_d   = 1'b1;
                  cdat_d = fdat_q;  ctag_d = ftag_q;  cv_d = 1'b1;
                  fdat_d = cdat_q;  ftag_d = ctag_q;  fv_d = cv_q;
               end
`endif
               else begin
                  cur_d   = srv_a;
                  tmr_d   = '0;
                  sil_d   = 1'b0;
                  state_d = S_WAIT;
                  // after an aborted fetch the request is only issued once the late ack shows up
                  iss_d   = aligned;
                  if (aligned) begin
                     a_d   = srv_w;
                     req_d = ~req_q;
                  end
               end
            end
         end

         S_WAIT: begin
            if (aligned && iss_q) begin
               state_d = S_IDLE;
               if (!quiet) begin
                  cdat_d = bus.port_q;
                  ctag_d = a_q;
                  cv_d   = 1'b1;
                  din_d  = cur_q[0] ? bus.port_q[15:8] : bus.port_q[7:0];
                  dv_d   = 1'b1;
               end
`ifdef IOCTL_UPLOAD_PREFETCH_EN
               if (!quiet && !pv_q && !rd_ok) begin
                  state_d = S_PREF;
                  a_d     = a_q + 1'b1;
                  req_d   = ~req_q;
                  tmr_d   = '0;
                  fv_d    = 1'b0;
               end
`endif
            end else if (aligned) begin
               if (quiet) state_d = S_IDLE;
               else begin
                  a_d   = cur_q[AW:1];
                  req_d = ~req_q;
                  iss_d = 1'b1;
                  tmr_d = '0;
               end
            end else if (tmr_q == TMAX) begin
               state_d = S_IDLE;
               cv_d    = 1'b0;
               if (!quiet) begin
                  din_d = 8'hFF;
                  dv_d  = 1'b1;
                  eto_d = 1'b1;
               end
            end else tmr_d = tmr_q + 1'b1;
         end

`ifdef IOCTL_UPLOAD_PREFETCH_EN
         S_PREF: begin
            if (aligned) begin
               state_d = S_IDLE;
               if (!quiet) begin
                  fdat_d = bus.port_q;
                  ftag_d = a_q;
                  fv_d   = 1'b1;
               end
            end else if (tmr_q == TMAX) begin
               state_d = S_IDLE;
               fv_d    = 1'b0;
            end else tmr_d = tmr_q + 1'b1;
         end
`endif

         default: state_d = S_IDLE;
      endcase

      if (upl_fall) begin
         cv_d = 1'b0;
         pv_d = 1'b0;
`ifdef IOCTL_UPLOAD_PREFETCH_EN
         fv_d = 1'b0;
`endif
         if (state_q != S_IDLE) sil_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;  upl_q <= 1'b0;  din_q <= 8'hFF;  dv_q <= 1'b0;
         req_q   <= 1'b0;    a_q   <= '0;    eto_q <= 1'b0;   eov_q <= 1'b0;
         cdat_q  <= '0;      ctag_q <= '0;   cv_q  <= 1'b0;
         pv_q    <= 1'b0;    paddr_q <= '0;  cur_q <= '0;
         iss_q   <= 1'b0;    sil_q <= 1'b0;  tmr_q <= '0;
`ifdef IOCTL_UPLOAD_PREFETCH_EN
         fdat_q  <= '0;      ftag_q <= '0;   fv_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d; upl_q <= bus.ioctl_upload; din_q <= din_d; dv_q <= dv_d;
         req_q   <= req_d;   a_q   <= a_d;   eto_q <= eto_d;  eov_q <= eov_d;
         cdat_q  <= cdat_d;  ctag_q <= ctag_d; cv_q <= cv_d;
         pv_q    <= pv_d;    paddr_q <= paddr_d; cur_q <= cur_d;
         iss_q   <= iss_d;   sil_q <= sil_d; tmr_q <= tmr_d;
`ifdef IOCTL_UPLOAD_PREFETCH_EN
         fdat_q  <= fdat_d;  ftag_q <= ftag_d; fv_q <= fv_d;
`endif
      end
   end

   assign bus.ioctl_din   = din_q;
   assign bus.din_valid   = dv_q;
   assign bus.port_req    = req_q;
   assign bus.port_a      = a_q;
   assign bus.busy        = (state_q != S_IDLE) | pv_q;
   assign bus.err_timeout = eto_q;
   assign bus.err_overrun = eov_q;
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader (default build): directed scenarios plus random reads against a
// one-word-cache reference model and a behavioural toggle-handshake SDRAM.
module tb_ioctl_upload_reader;
   localparam int TO = 40;

   logic clk_sys = 1'b0;
   logic reset;
   always #5 clk_sys = ~clk_sys;

   ioctl_upload_reader_if #(.AW(23)) ifc();
   ioctl_upload_reader #(.AW(23), .TIMEOUT(TO)) dut (.clk_sys(clk_sys), .reset(reset), .bus(ifc.slave));

   int   n_chk = 0, n_pass = 0;
   int   n_dv = 0, n_tog = 0;
   logic prev_req = 1'b0;
   logic [7:0] got_q[$];
   logic mute = 1'b0;
   int   ack_dly = 0, ack_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [15:0] mem_w(input logic [22:0] w);
      if (w == 23'h8) return 16'hBEEF;
      return {w[7:0] ^ 8'hC3, (w[7:0] + 8'h11) ^ w[15:8]};
   endfunction

   function automatic logic [7:0] mem_b(input logic [23:0] a);
      logic [15:0] w;
      w = mem_w(a[23:1]);
      return a[0] ? w[15:8] : w[7:0];
   endfunction

   // SDRAM: answers a pending toggle after ack_dly cycles unless muted
   initial begin
      ifc.port_ack = 1'b0;
      ifc.port_q   = '0;
      forever begin
         @(posedge clk_sys); #1;
         if (reset) begin
            ifc.port_ack = 1'b0;
            ack_cnt = 0;
         end else if (ifc.port_req != ifc.port_ack && !mute) begin
            if (ack_cnt >= ack_dly) begin
               ifc.port_q   = mem_w(ifc.port_a);
               ifc.port_ack = ifc.port_req;
               ack_cnt = 0;
            end else ack_cnt++;
         end else ack_cnt = 0;
      end
   end

   initial begin
      forever begin
         @(negedge clk_sys);
         if (ifc.din_valid) begin
            n_dv++;
            got_q.push_back(ifc.ioctl_din);
         end
         if (ifc.port_req !== prev_req) n_tog++;
         prev_req = ifc.port_req;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse(input logic [23:0] a);
      ifc.ioctl_rd   = 1'b1;
      ifc.ioctl_addr = a;
      @(negedge clk_sys);
      ifc.ioctl_rd   = 1'b0;
   endtask

   // lat counts falling edges after the strobe: 1 = hit, dly+2 = miss, TO+2 = timeout
   task automatic rd_wait(input logic [23:0] a, output int lat, output logic [7:0] d);
      pulse(a);
      lat = 1;
      while (!ifc.din_valid && lat < 400) begin
         @(negedge clk_sys);
         lat++;
      end
      chk("rd_response_seen", ifc.din_valid, 1'b1);
      d = ifc.ioctl_din;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (ifc.busy && n < 500) begin
         @(negedge clk_sys);
         n++;
      end
      chk("idle_bound", ifc.busy, 1'b0);
   endtask

   initial begin
      int lat, t0, v0;
      logic [7:0] d;
      logic [23:0] a;
      logic cv;
      logic [22:0] cw;
      int exp_lat;
      logic hit;
      int lats[4];

      reset = 1'b1;
      ifc.ioctl_upload = 1'b0;
      ifc.ioctl_rd = 1'b0;
      ifc.ioctl_addr = '0;
      repeat (3) @(negedge clk_sys);
      chk("rst_din", ifc.ioctl_din, 8'hFF);
      chk("rst_dv", ifc.din_valid, 0);
      chk("rst_req", ifc.port_req, 0);
      chk("rst_a", ifc.port_a, 0);
      chk("rst_busy", ifc.busy, 0);
      chk("rst_eto", ifc.err_timeout, 0);
      chk("rst_eov", ifc.err_overrun, 0);
      reset = 1'b0;
      @(negedge clk_sys);
      ifc.ioctl_upload = 1'b1;
      @(negedge clk_sys);

      // basic miss then hit on the odd byte
      ack_dly = 5; t0 = n_tog; v0 = n_dv;
      rd_wait(24'h10, lat, d);
      chk("miss_byte", d, 8'hEF);
      chk("miss_lat", lat, 7);
      chk("miss_toggle", n_tog - t0, 1);
      @(negedge clk_sys);
      chk("miss_one_pulse", n_dv - v0, 1);
      t0 = n_tog;
      rd_wait(24'h11, lat, d);
      chk("hit_byte", d, 8'hBE);
      chk("hit_lat", lat, 1);
      chk("hit_no_toggle", n_tog - t0, 0);

      // timeout, then late ack must not produce a response
      mute = 1'b1;
      rd_wait(24'h20, lat, d);
      chk("to_byte", d, 8'hFF);
      chk("to_lat", lat, TO + 2);
      chk("to_err", ifc.err_timeout, 1);
      mute = 1'b0; ack_dly = 3; t0 = n_tog; v0 = n_dv;
      rd_wait(24'h30, lat, d);
      chk("after_to_byte", d, mem_b(24'h30));
      chk("after_to_toggle", n_tog - t0, 1);
      wait_idle();
      repeat (3) @(negedge clk_sys);
      chk("late_ack_ignored", n_dv - v0, 1);
      chk("to_err_sticky", ifc.err_timeout, 1);

      // session end during a fetch
      ack_dly = 8; v0 = n_dv;
      pulse(24'h70);
      repeat (2) @(negedge clk_sys);
      ifc.ioctl_upload = 1'b0;
      wait_idle();
      repeat (3) @(negedge clk_sys);
      chk("drop_silent", n_dv - v0, 0);
      ifc.ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);
      chk("rise_clr_eto", ifc.err_timeout, 0);
      t0 = n_tog;
      rd_wait(24'h70, lat, d);
      chk("refetch_byte", d, mem_b(24'h70));
      chk("refetch_lat", lat, 10);
      chk("refetch_toggle", n_tog - t0, 1);

      // three strobes during one fetch: second queued, third dropped
      ack_dly = 10;
      @(negedge clk_sys);
      got_q.delete();
      pulse(24'h40); pulse(24'h52); pulse(24'h60);
      wait_idle();
      repeat (3) @(negedge clk_sys);
      chk("ovr_count", got_q.size(), 2);
      chk("ovr_first", got_q[0], mem_b(24'h40));
      chk("ovr_second", got_q[1], mem_b(24'h52));
      chk("ovr_err", ifc.err_overrun, 1);

      // reset while a fetch is outstanding
      mute = 1'b1;
      pulse(24'h80);
      repeat (3) @(negedge clk_sys);
      chk("mid_busy", ifc.busy, 1);
      reset = 1'b1;
      @(negedge clk_sys);
      chk("mid_rst_din", ifc.ioctl_din, 8'hFF);
      chk("mid_rst_dv", ifc.din_valid, 0);
      chk("mid_rst_req", ifc.port_req, 0);
      chk("mid_rst_a", ifc.port_a, 0);
      chk("mid_rst_busy", ifc.busy, 0);
      chk("mid_rst_eov", ifc.err_overrun, 0);
      reset = 1'b0; mute = 1'b0;
      repeat (2) @(negedge clk_sys);

      // sequential bytes: without prefetch every new word costs a round trip
      ack_dly = 4;
      lats = '{6, 1, 6, 1};
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         a = 24'h100 + 24'(i);
         rd_wait(a, lat, d);
         chk("seq_byte", d, mem_b(a));
         chk("seq_lat", lat, lats[i]);
      end

      // top of address space
      ack_dly = 2;
      rd_wait(24'hFFFFFF, lat, d);
      chk("wrap_port_a", ifc.port_a, 23'h7FFFFF);
      chk("wrap_byte", d, mem_b(24'hFFFFFF));

      // random reads against a single-word cache model
      cv = 1'b1; cw = 23'h7FFFFF;
      for (int i = 0; i < 40; i++) begin
         wait_idle();
         ack_dly = int'($urandom_range(0, 6));
         a = 24'h200 + 24'($urandom_range(0, 15));
         hit = cv && (cw == a[23:1]);
         exp_lat = hit ? 1 : ack_dly + 2;
         t0 = n_tog;
         rd_wait(a, lat, d);
         chk("rnd_byte", d, mem_b(a));
         chk("rnd_lat", lat, exp_lat);
         chk("rnd_toggle", n_tog - t0, hit ? 0 : 1);
         cv = 1'b1; cw = a[23:1];
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
